// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Optional leading-zero blanking output is enabled with BIN2BCD_BLANK_EN.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam bcd_digit_t BCD_ADD3_THRESH = 4'd5;
  localparam bcd_digit_t BCD_ADD3_VAL    = 4'd3;

  // Constant-foldable ceiling log2, used to size the shift counter
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Per-digit double-dabble correction: adds 3 to any BCD digit of 5 or more
// so that the following left shift carries correctly into the next digit.
module bcd_add3
  import bcd_pkg::*;
(
  input  bcd_digit_t digit_in,
  output bcd_digit_t digit_out
);

  always_comb begin
    if (digit_in >= BCD_ADD3_THRESH) begin
      digit_out = digit_in + BCD_ADD3_VAL;
    end else begin
      digit_out = digit_in;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock,
// with valid/ready on both sides. Define BIN2BCD_BLANK_EN to add out_blank.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  out_ovf
`ifdef BIN2BCD_BLANK_EN
  ,
  output logic [DIGITS-1:0]     out_blank
`endif
);

  localparam int ACC_W = 4 * DIGITS;
  localparam int CNT_W = clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  logic [BIN_W-1:0] shreg;
  logic [ACC_W-1:0] acc;
  logic             ovf;
  logic [CNT_W-1:0] cnt;

  logic [ACC_W-1:0] acc_fixed;
  logic [ACC_W-1:0] acc_next;
  logic             ovf_next;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_add3 u_add3 (
      .digit_in  (acc[4*g +: 4]),
      .digit_out (acc_fixed[4*g +: 4])
    );
  end

  // A set bit 3 in the corrected top digit is about to fall off the
  // accumulator; the sticky flag is the only record that it existed.
  assign ovf_next = ovf | acc_fixed[ACC_W-1];
  assign acc_next = {acc_fixed[ACC_W-2:0], shreg[BIN_W-1]};

`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0] blank_next;

  // Digit 0 is never blanked so that a zero value still shows a single "0"
  always_comb begin
    logic upper_zero;
    blank_next = '0;
    upper_zero = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      upper_zero    = upper_zero & (acc_next[4*k +: 4] == 4'd0);
      blank_next[k] = upper_zero;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_bcd   <= '0;
      out_ovf   <= 1'b0;
      shreg     <= '0;
      acc       <= '0;
      ovf       <= 1'b0;
      cnt       <= '0;
`ifdef BIN2BCD_BLANK_EN
      out_blank <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            shreg    <= in_data;
            acc      <= '0;
            ovf      <= 1'b0;
            cnt      <= CNT_LOAD;
            in_ready <= 1'b0;
            state    <= SHIFT;
          end else begin
            in_ready <= 1'b1;
          end
        end

        SHIFT: begin
          acc   <= acc_next;
          shreg <= shreg << 1;
          ovf   <= ovf_next;
          cnt   <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_bcd   <= acc_next;
            out_ovf   <= ovf_next;
`ifdef BIN2BCD_BLANK_EN
            out_blank <= blank_next;
`endif
          end
        end

        // in_ready is raised here so the next value can be taken one cycle
        // after the result handshake, giving a BIN_W+2 cycle period.
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Randomised bench for bin2bcd_seq: a 3-digit and a 2-digit converter run
// in lock-step and are compared against a plain arithmetic decimal model.
module tb_bin2bcd_seq;

  localparam int BIN_W = 8;
  localparam int DIG_A = 3;
  localparam int DIG_B = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic [BIN_W-1:0] in_data;
  logic             out_ready;

  logic             in_ready_a, out_valid_a, out_ovf_a;
  logic [11:0]      out_bcd_a;
  logic             in_ready_b, out_valid_b, out_ovf_b;
  logic [7:0]       out_bcd_b;
`ifdef BIN2BCD_BLANK_EN
  logic [DIG_A-1:0] out_blank_a;
  logic [DIG_B-1:0] out_blank_b;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIG_A)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready_a),
    .in_data   (in_data),
    .out_valid (out_valid_a),
    .out_ready (out_ready),
    .out_bcd   (out_bcd_a),
    .out_ovf   (out_ovf_a)
`ifdef BIN2BCD_BLANK_EN
    ,
    .out_blank (out_blank_a)
`endif
  );

  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIG_B)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready_b),
    .in_data   (in_data),
    .out_valid (out_valid_b),
    .out_ready (out_ready),
    .out_bcd   (out_bcd_b),
    .out_ovf   (out_ovf_b)
`ifdef BIN2BCD_BLANK_EN
    ,
    .out_blank (out_blank_b)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pow10(input int d);
    int p;
    p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    return p;
  endfunction

  // Decimal digits of v, lowest 'digits' of them, packed four bits each
  function automatic logic [31:0] ref_bcd(input int v, input int digits);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < digits; k++) begin
      r = r | (32'((v / pow10(k)) % 10) << (4 * k));
    end
    return r;
  endfunction

  function automatic logic [31:0] ref_blank(input int v, input int digits);
    logic [31:0] r;
    int shown;
    r = '0;
    shown = v % pow10(digits);
    for (int k = 1; k < digits; k++) begin
      if (shown < pow10(k)) r[k] = 1'b1;
    end
    return r;
  endfunction

  task automatic checkResult(input int v, input string tag);
    checkOutput({tag, "_bcd_a"}, 32'(out_bcd_a), ref_bcd(v, DIG_A));
    checkOutput({tag, "_ovf_a"}, 32'(out_ovf_a), 32'(v >= pow10(DIG_A)));
    checkOutput({tag, "_bcd_b"}, 32'(out_bcd_b), ref_bcd(v, DIG_B));
    checkOutput({tag, "_ovf_b"}, 32'(out_ovf_b), 32'(v >= pow10(DIG_B)));
`ifdef BIN2BCD_BLANK_EN
    checkOutput({tag, "_blank_a"}, 32'(out_blank_a), ref_blank(v, DIG_A));
    checkOutput({tag, "_blank_b"}, 32'(out_blank_b), ref_blank(v, DIG_B));
`endif
  endtask

  task automatic waitReady();
    int waited;
    waited = 0;
    while (!in_ready_a && waited < 20) begin
      tick();
      waited++;
    end
    checkOutput("ready_wait", 32'(in_ready_a), 32'd1);
  endtask

  task automatic waitValid(input int acc_edge);
    int waited;
    waited = 0;
    while (!out_valid_a && waited < 20) begin
      tick();
      waited++;
    end
    checkOutput("latency", 32'(cyc - acc_edge), 32'(BIN_W));
    checkOutput("valid_b", 32'(out_valid_b), 32'd1);
    checkOutput("ready_in_done", 32'(in_ready_a), 32'd0);
  endtask

  // One conversion with 'hold' cycles of consumer backpressure
  task automatic applyStimulus(input int v, input int hold);
    int acc_edge;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = BIN_W'(v);
    waitReady();
    tick();
    acc_edge = cyc;
    in_valid = 1'b0;
    in_data  = BIN_W'($urandom);
    checkOutput("ready_busy", 32'(in_ready_a), 32'd0);
    waitValid(acc_edge);
    checkResult(v, "res");
    for (int i = 0; i < hold; i++) begin
      in_data = BIN_W'($urandom);
      tick();
      checkOutput("hold_valid", 32'(out_valid_a), 32'd1);
      checkResult(v, "hold");
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("drop_valid", 32'(out_valid_a), 32'd0);
    checkOutput("ready_back", 32'(in_ready_a), 32'd1);
  endtask

  // Back-to-back conversions with in_valid and out_ready held high
  task automatic streamTest(input int n);
    int vals[$];
    int acc_edge;
    int prev_edge;
    vals.push_back(255);
    vals.push_back(99);
    for (int i = 2; i < n; i++) vals.push_back(int'($urandom_range(0, 255)));
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = BIN_W'(vals[0]);
    prev_edge = 0;
    waitReady();
    for (int i = 0; i < n; i++) begin
      tick();
      acc_edge = cyc;
      if (i > 0) checkOutput("throughput", 32'(acc_edge - prev_edge), 32'(BIN_W + 2));
      prev_edge = acc_edge;
      in_data = BIN_W'($urandom);
      waitValid(acc_edge);
      checkResult(vals[i], "stream");
      if (i + 1 < n) in_data = BIN_W'(vals[i + 1]);
      tick();
      checkOutput("stream_drop", 32'(out_valid_a), 32'd0);
      checkOutput("stream_ready", 32'(in_ready_a), 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic midShiftReset();
    int seen;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = BIN_W'(200);
    waitReady();
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    checkOutput("rst_ready", 32'(in_ready_a), 32'd0);
    checkOutput("rst_valid", 32'(out_valid_a), 32'd0);
    checkOutput("rst_bcd", 32'(out_bcd_a), 32'd0);
    checkOutput("rst_ovf", 32'(out_ovf_a), 32'd0);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid_a || out_valid_b) seen = 1;
    end
    checkOutput("no_pulse", 32'(seen), 32'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = BIN_W'(42);
    out_ready = 1'b0;
    tick();
    tick();
    tick();
    checkOutput("reset_ready", 32'(in_ready_a), 32'd0);
    checkOutput("reset_valid", 32'(out_valid_a), 32'd0);
    checkOutput("reset_bcd", 32'(out_bcd_a), 32'd0);
    checkOutput("reset_ovf", 32'(out_ovf_a), 32'd0);
    checkOutput("reset_valid_b", 32'(out_valid_b), 32'd0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    tick();
    checkOutput("release_ready", 32'(in_ready_a), 32'd1);
    checkOutput("release_ready_b", 32'(in_ready_b), 32'd1);

    applyStimulus(0, 0);
    applyStimulus(128, 10);
    applyStimulus(150, 2);
    applyStimulus(99, 0);
    applyStimulus(100, 1);
    applyStimulus(9, 0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(int'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
    end

    streamTest(6);

    midShiftReset();
    applyStimulus(7, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
